// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM state type for the SPI configuration master.
package spi_cfg_pkg;
   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

   localparam int   ADDR_W     = 7;
   localparam int   DATA_W     = 8;
   localparam int   FRAME_W    = 16;
   localparam logic WRITE_FLAG = 1'b1;
   // FIFO entries omit the write flag; it is constant and re-inserted on the wire.
   localparam int   REQ_W      = FRAME_W - 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCLK_HI,
      SCLK_LO,
      GAP
   } spi_state_e;
endpackage

// File: rtl/spi_cfg_if.sv
// Host request channel: valid/ready handshake carrying (address, data).
interface spi_cfg_if;
   import spi_cfg_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;

   modport master (output req_valid, req_addr, req_data, input req_ready);
   modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_cfg_fifo.sv
// Synchronous request FIFO; extra pointer bit distinguishes full from empty.
module spi_cfg_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;

   // Pointer update; writes into a full FIFO and reads from an empty one are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)  wptr <= wptr + 1'b1;
         if (pop  && !empty) rptr <= rptr + 1'b1;
      end
   end

   // Storage array, no reset needed since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[AW-1:0]] <= din;
   end

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign dout  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write-frame sequencer for the on-chip config register peripheral.
// Optional macro SPI_CFG_SHADOW_EN adds local shadow copies of the five registers.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYC    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   spi_cfg_if.slave  bus,
   output logic      sclk,
   output logic      ncs,
   output logic      copi,
   output logic      busy,
   output logic      frame_done
`ifdef SPI_CFG_SHADOW_EN
   ,
   output logic [7:0] shadow_en_out_7_0,
   output logic [7:0] shadow_en_out_15_8,
   output logic [7:0] shadow_en_pwm_7_0,
   output logic [7:0] shadow_en_pwm_15_8,
   output logic [7:0] shadow_pwm_duty
`endif
);
   localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX);

   spi_state_e       state, state_d;
   logic [CW-1:0]    hcnt, hcnt_d;
   logic [3:0]       bcnt, bcnt_d;
   logic [REQ_W-1:0] shreg, shreg_d;   // bits still to be sent after the current one
   logic             sclk_d, ncs_d, copi_d, done_d;

   logic             fifo_full, fifo_empty, pop, push;
   logic [REQ_W-1:0] fifo_dout;

   assign bus.req_ready = !fifo_full;
   assign push          = bus.req_valid && !fifo_full;
   assign busy          = (state != IDLE) || !fifo_empty;

   spi_cfg_fifo #(.DEPTH(FIFO_DEPTH), .W(REQ_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({bus.req_addr, bus.req_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   wire half_end = (hcnt == CW'(CLK_DIV - 1));

   // Next-state and next-output logic; pins are registered so they are glitch-free.
   always_comb begin
      state_d = state;
      hcnt_d  = hcnt;
      bcnt_d  = bcnt;
      shreg_d = shreg;
      sclk_d  = sclk;
      ncs_d   = ncs;
      copi_d  = copi;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_dout;
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
               copi_d  = WRITE_FLAG;
               hcnt_d  = '0;
               bcnt_d  = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (half_end) begin
               hcnt_d  = '0;
               sclk_d  = 1'b1;
               state_d = SCLK_HI;
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         SCLK_HI: begin
            if (half_end) begin
               hcnt_d  = '0;
               sclk_d  = 1'b0;
               state_d = SCLK_LO;
               // Advance data on the falling edge; the last bit is held through nCS hold.
               if (bcnt != 4'(FRAME_W - 1)) begin
                  copi_d  = shreg[REQ_W-1];
                  shreg_d = {shreg[REQ_W-2:0], 1'b0};
               end
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         SCLK_LO: begin
            if (half_end) begin
               hcnt_d = '0;
               if (bcnt == 4'(FRAME_W - 1)) begin
                  ncs_d   = 1'b1;
                  copi_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = GAP;
               end else begin
                  bcnt_d  = bcnt + 1'b1;
                  sclk_d  = 1'b1;
                  state_d = SCLK_HI;
               end
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         GAP: begin
            if (hcnt == CW'(GAP_CYC - 1)) begin
               hcnt_d  = '0;
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters, shift register and SPI pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hcnt       <= '0;
         bcnt       <= '0;
         shreg      <= '0;
         sclk       <= 1'b0;
         ncs        <= 1'b1;
         copi       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         hcnt       <= hcnt_d;
         bcnt       <= bcnt_d;
         shreg      <= shreg_d;
         sclk       <= sclk_d;
         ncs        <= ncs_d;
         copi       <= copi_d;
         frame_done <= done_d;
      end
   end

`ifdef SPI_CFG_SHADOW_EN
   logic [REQ_W-1:0] cur_req;

   // Remember the in-flight request and commit its data when the frame closes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_req            <= '0;
         shadow_en_out_7_0  <= '0;
         shadow_en_out_15_8 <= '0;
         shadow_en_pwm_7_0  <= '0;
         shadow_en_pwm_15_8 <= '0;
         shadow_pwm_duty    <= '0;
      end else begin
         if (pop) cur_req <= fifo_dout;
         if (done_d) begin
            case (cur_req[REQ_W-1 -: ADDR_W])
               ADDR_EN_OUT_LO: shadow_en_out_7_0  <= cur_req[DATA_W-1:0];
               ADDR_EN_OUT_HI: shadow_en_out_15_8 <= cur_req[DATA_W-1:0];
               ADDR_EN_PWM_LO: shadow_en_pwm_7_0  <= cur_req[DATA_W-1:0];
               ADDR_EN_PWM_HI: shadow_en_pwm_15_8 <= cur_req[DATA_W-1:0];
               ADDR_PWM_DUTY:  shadow_pwm_duty    <= cur_req[DATA_W-1:0];
               default: ;
            endcase
         end
      end
   end
`endif
endmodule

// File: tb/tb_spi_cfg_master.sv
// Self-checking bench for spi_cfg_master: vector table, directed corner cases,
// randomized traffic against a frame-level scoreboard, and a peripheral loopback.
module tb_spi_cfg_master;
   localparam int CLK_DIV    = 4;
   localparam int GAP_CYC    = 8;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk, ncs, copi, busy, frame_done;
   int   checks = 0;
   int   errors = 0;

   spi_cfg_if bus();

   always #5 clk = ~clk;

`ifdef SPI_CFG_SHADOW_EN
   logic [7:0] sh_act [5];
   logic [7:0] sh_ref [5];
`endif

   spi_cfg_master #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sclk       (sclk),
      .ncs        (ncs),
      .copi       (copi),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef SPI_CFG_SHADOW_EN
      ,
      .shadow_en_out_7_0  (sh_act[0]),
      .shadow_en_out_15_8 (sh_act[1]),
      .shadow_en_pwm_7_0  (sh_act[2]),
      .shadow_en_pwm_15_8 (sh_act[3]),
      .shadow_pwm_duty    (sh_act[4])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard: expected frames in acceptance order ----------------
   logic [15:0] exp_q [$];

   initial begin
      forever begin
         @(posedge clk);
         if (rst) exp_q.delete();
         else if (bus.req_valid && bus.req_ready)
            exp_q.push_back({1'b1, bus.req_addr, bus.req_data});
      end
   end

   // ---------------- SPI pin monitor ----------------
   logic [15:0] mon_word  = '0;
   logic [15:0] last_word = '0;
   int  mon_rises = 0, mon_low = 0, hi_run = 0;
   int  frames_seen = 0, done_cnt = 0;
   bit  in_fr = 0, gap_ok = 0;
   logic sclk_q = 1'b0, copi_q = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_fr  = 0;
            gap_ok = 0;
`ifdef SPI_CFG_SHADOW_EN
            for (int i = 0; i < 5; i++) sh_ref[i] = 8'h00;
`endif
         end else begin
            if (frame_done) done_cnt++;
            if (!ncs) begin
               if (!in_fr) begin
                  if (gap_ok) chk("gap_ncs_high_min", 32'(hi_run >= GAP_CYC), 32'd1);
                  in_fr = 1; mon_word = '0; mon_rises = 0; mon_low = 0;
               end
               mon_low++;
               if (sclk && !sclk_q) begin
                  mon_word = {mon_word[14:0], copi};
                  mon_rises++;
               end
               if (sclk && sclk_q) chk("copi_stable_sclk_hi", 32'(copi), 32'(copi_q));
               chk("no_done_while_ncs_low", 32'(frame_done), 32'd0);
            end else if (in_fr) begin
               in_fr = 0;
               chk("done_at_ncs_rise", 32'(frame_done), 32'd1);
               chk("ncs_low_cycles", 32'(mon_low), 32'(33 * CLK_DIV));
               chk("sclk_rises", 32'(mon_rises), 32'd16);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL frame_unexpected: got frame 0x%h, expected no frame", mon_word);
               end else begin
                  logic [15:0] ew;
                  ew = exp_q.pop_front();
                  chk("frame_word", 32'(mon_word), 32'(ew));
`ifdef SPI_CFG_SHADOW_EN
                  if (int'(ew[14:8]) < 5) sh_ref[int'(ew[14:8])] = ew[7:0];
                  for (int i = 0; i < 5; i++)
                     chk($sformatf("shadow%0d", i), 32'(sh_act[i]), 32'(sh_ref[i]));
`endif
               end
               last_word = mon_word;
               frames_seen++;
               hi_run = 1;
               gap_ok = 1;
            end else begin
               hi_run++;
               chk("no_spurious_done", 32'(frame_done), 32'd0);
            end
         end
         sclk_q = sclk;
         copi_q = copi;
      end
   end

   // ---------------- peripheral model: 2-flop synchronisers, active-low reset ----------------
   logic       p_rst_n;
   logic [2:0] p_sclk, p_ncs;
   logic [1:0] p_copi;
   logic [15:0] p_sh;
   logic [4:0] p_cnt;
   logic [7:0] p_reg [5];
   assign p_rst_n = !rst;

   always @(posedge clk) begin
      if (!p_rst_n) begin
         p_sclk <= 3'b000; p_ncs <= 3'b111; p_copi <= 2'b00; p_sh <= '0; p_cnt <= '0;
         for (int i = 0; i < 5; i++) p_reg[i] <= 8'h00;
      end else begin
         p_sclk <= {p_sclk[1:0], sclk};
         p_ncs  <= {p_ncs[1:0], ncs};
         p_copi <= {p_copi[0], copi};
         if (!p_ncs[1] && p_sclk[1] && !p_sclk[2]) begin
            p_sh  <= {p_sh[14:0], p_copi[1]};
            p_cnt <= p_cnt + 5'd1;
         end
         if (p_ncs[1] && !p_ncs[2]) begin
            p_cnt <= '0;
            if (p_cnt == 5'd16 && p_sh[15] && p_sh[14:8] < 7'd5) p_reg[p_sh[10:8]] <= p_sh[7:0];
         end
      end
   end

   // ---------------- host-side helpers (inputs change 2 units after posedge) ----------------
   task automatic push(input logic [6:0] a, input logic [7:0] d);
      bit ok = 0;
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d;
      for (int t = 0; t < 3000; t++) begin
         if (bus.req_ready) begin ok = 1; @(posedge clk); #2; break; end
         @(posedge clk); #2;
      end
      bus.req_valid = 1'b0;
      chk("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk); #1;
         if (frame_done) begin seen = 1; break; end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_ncs_low();
      bit seen = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk); #1;
         if (!ncs) begin seen = 1; break; end
      end
      chk("ncs_went_low", 32'(seen), 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      bit seen = 0;
      for (int t = 0; t < bound; t++) begin
         @(negedge clk); #1;
         if (!busy) begin seen = 1; break; end
      end
      chk("reached_idle", 32'(seen), 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] word;
   } vec_t;
   vec_t tbl [7];

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, d0, low_cnt, n;
      logic [7:0] exp_p [5];

      tbl[0] = '{7'h04, 8'h80, 16'h8480};
      tbl[1] = '{7'h7F, 8'hAA, 16'hFFAA};
      tbl[2] = '{7'h00, 8'h5A, 16'h805A};
      tbl[3] = '{7'h03, 8'hF0, 16'h83F0};
      tbl[4] = '{7'h44, 8'h80, 16'hC480};
      tbl[5] = '{7'h05, 8'h01, 16'h8501};
      tbl[6] = '{7'h2A, 8'hC3, 16'hAAC3};

      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_ncs", 32'(ncs), 32'd1);
      chk("rst_copi", 32'(copi), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
`ifdef SPI_CFG_SHADOW_EN
      for (int i = 0; i < 5; i++) chk($sformatf("rst_shadow%0d", i), 32'(sh_act[i]), 32'd0);
`endif
      rst = 1'b0;

      // Single frames: word on the wire, then busy drops exactly GAP_CYC cycles after frame_done.
      foreach (tbl[i]) begin
         push(tbl[i].addr, tbl[i].data);
         wait_done($sformatf("tbl%0d_done", i));
         chk($sformatf("tbl%0d_word", i), 32'(last_word), 32'(tbl[i].word));
         repeat (GAP_CYC - 1) @(negedge clk);
         #1;
         chk($sformatf("tbl%0d_busy_in_gap", i), 32'(busy), 32'd1);
         @(negedge clk); #1;
         chk($sformatf("tbl%0d_busy_after_gap", i), 32'(busy), 32'd0);
      end

      // Burst of 5 while a frame is in flight: 4 fit, the 5th waits for the next pop.
      f0 = frames_seen;
      push(7'h01, 8'h11);
      wait_ncs_low();
      @(posedge clk); #2;
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = 7'(16 + i);
         bus.req_data  = 8'(176 + i);
         chk($sformatf("burst_ready%0d", i), 32'(bus.req_ready), 32'(i < 4));
         if (i < 4) begin @(posedge clk); #2; end
      end
      push(7'(20), 8'(180));
      chk("burst_5th_after_first_frame", 32'(frames_seen - f0), 32'd1);
      wait_idle(3000);
      chk("burst_frame_count", 32'(frames_seen - f0), 32'd6);

      // Reset 50 cycles into a frame with two requests queued behind it.
      push(7'h00, 8'h01);
      push(7'h01, 8'h02);
      push(7'h02, 8'h03);
      wait_ncs_low();
      repeat (49) @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      bus.req_valid = 1'b1; bus.req_addr = 7'h04; bus.req_data = 8'h99;
      d0 = done_cnt; f0 = frames_seen;
      @(posedge clk); #2;
      chk("midrst_ncs", 32'(ncs), 32'd1);
      chk("midrst_sclk", 32'(sclk), 32'd0);
      chk("midrst_copi", 32'(copi), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      low_cnt = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk); #1;
         if (!ncs) low_cnt++;
      end
      chk("postrst_no_frames", 32'(low_cnt), 32'd0);
      chk("postrst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);

      // Randomized traffic; every frame is checked by the scoreboard in the monitor.
      f0 = frames_seen;
      for (int i = 0; i < 24; i++) begin
         push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) begin @(posedge clk); #2; end
      end
      wait_idle(20000);
      chk("rand_frame_count", 32'(frames_seen - f0), 32'd24);
      chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

      // Loopback into the peripheral model.
      exp_p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) push(7'(i), exp_p[i]);
      begin
         bit seen = 0;
         for (int t = 0; t < 3000; t++) begin
            if (done_cnt - d0 >= 5) begin seen = 1; break; end
            @(negedge clk); #1;
         end
         chk("loop_all_done", 32'(seen), 32'd1);
      end
      repeat (4) @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) chk($sformatf("periph_reg%0d", i), 32'(p_reg[i]), 32'(exp_p[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
